// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared configuration and types for the single-clock FIFO controller.
// Holds the default FIFO depth/data width and the default almost-empty level.
package sync_fifo_ctrl_pkg;

    localparam int unsigned CFG_FIFO_DEPTH = 4;
    localparam int unsigned CFG_DATA_WIDTH = 8;
    localparam int unsigned CFG_AE_LEVEL   = 1;

    // Accepted operation in a cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OpIdle = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sync_fifo_ptr.sv
// Index + wrap-bit pointer for the FIFO; index wraps from DEPTH-1 to 0 and
// toggles the wrap bit, so any DEPTH >= 2 is supported.
module sync_fifo_ptr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [AW-1:0] idx,
    output logic          wrap,
    output logic [AW-1:0] idx_nxt,
    output logic          wrap_nxt
);

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    logic [AW-1:0] idx_q;
    logic          wrap_q;

    always_comb begin
        idx_nxt  = idx_q;
        wrap_nxt = wrap_q;
        if (inc) begin
            if (idx_q == LastIdx) begin
                idx_nxt  = '0;
                wrap_nxt = ~wrap_q;
            end else begin
                idx_nxt = idx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller for the single-clock first-word-fall-through FIFO.
// Define SYNC_FIFO_ALMOST_FLAG_EN to add registered almost_full/almost_empty outputs.
module sync_fifo_ctrl import sync_fifo_ctrl_pkg::*; #(
    parameter int unsigned MEM_DEPTH  = CFG_FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int unsigned CNT_WIDTH  = ADDR_WIDTH + 1
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
    ,
    parameter int unsigned AF_LEVEL   = MEM_DEPTH - 1,
    parameter int unsigned AE_LEVEL   = CFG_AE_LEVEL
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic                  rd_req,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  wr_err,
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
    output logic                  almost_full,
    output logic                  almost_empty,
`endif
    output logic                  rd_err
);

    logic                  wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx, wr_idx_nxt, rd_idx_nxt;
    logic                  wr_wrap, rd_wrap, wr_wrap_nxt, rd_wrap_nxt;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  wr_err_q, wr_err_d, rd_err_q, rd_err_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    fifo_op_e              op;

    // Acceptance looks only at registered flags: a pop never frees a slot for a
    // push in the same cycle, and a push never feeds a pop in the same cycle.
    assign wr_acc = wr_req & ~full_q;
    assign rd_acc = rd_req & ~empty_q;

    sync_fifo_ptr #(
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_wr_ptr (
        .clk      (clk),
        .reset    (reset),
        .inc      (wr_acc),
        .idx      (wr_idx),
        .wrap     (wr_wrap),
        .idx_nxt  (wr_idx_nxt),
        .wrap_nxt (wr_wrap_nxt)
    );

    sync_fifo_ptr #(
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_rd_ptr (
        .clk      (clk),
        .reset    (reset),
        .inc      (rd_acc),
        .idx      (rd_idx),
        .wrap     (rd_wrap),
        .idx_nxt  (rd_idx_nxt),
        .wrap_nxt (rd_wrap_nxt)
    );

    always_comb begin
        op       = fifo_op_e'({wr_acc, rd_acc});
        count_d  = count_q;
        empty_d  = (wr_idx_nxt == rd_idx_nxt) && (wr_wrap_nxt == rd_wrap_nxt);
        full_d   = (wr_idx_nxt == rd_idx_nxt) && (wr_wrap_nxt != rd_wrap_nxt);
        wr_err_d = wr_req & full_q;
        rd_err_d = rd_req & empty_q;
        unique case (op)
            OpPush:  count_d = count_q + CNT_WIDTH'(1);
            OpPop:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

`ifdef SYNC_FIFO_ALMOST_FLAG_EN
    logic almost_full_q, almost_empty_q;

    // Reset values match an occupancy of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= count_d >= CNT_WIDTH'(AF_LEVEL);
            almost_empty_q <= count_d <= CNT_WIDTH'(AE_LEVEL);
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

    assign mem_wr_en   = wr_acc;
    assign mem_wr_addr = wr_idx;
    assign mem_rd_addr = rd_idx;
    assign full        = full_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign wr_err      = wr_err_q;
    assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: depth-4 instance with a bench-side memory
// for data ordering, plus a depth-3 instance for non-power-of-2 wrapping.
module tb_sync_fifo_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       wr_req, rd_req, mem_wr_en, full, empty, wr_err, rd_err;
    logic [1:0] mem_wr_addr, mem_rd_addr;
    logic [2:0] count;
    logic       wr3, rd3, wen3, full3, empty3, werr3, rerr3;
    logic [1:0] wa3_o, ra3_o;
    logic [2:0] count3;
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
    logic       almost_full, almost_empty, af3, ae3;
`endif

    sync_fifo_ctrl #(
        .MEM_DEPTH (4)
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
        ,
        .AF_LEVEL  (3),
        .AE_LEVEL  (1)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_rd_addr  (mem_rd_addr),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .wr_err       (wr_err),
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .rd_err       (rd_err)
    );

    sync_fifo_ctrl #(
        .MEM_DEPTH (3)
    ) dut3 (
        .clk          (clk),
        .reset        (reset),
        .wr_req       (wr3),
        .rd_req       (rd3),
        .mem_wr_en    (wen3),
        .mem_wr_addr  (wa3_o),
        .mem_rd_addr  (ra3_o),
        .full         (full3),
        .empty        (empty3),
        .count        (count3),
        .wr_err       (werr3),
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
        .almost_full  (af3),
        .almost_empty (ae3),
`endif
        .rd_err       (rerr3)
    );

    logic [7:0] wdata;
    logic [7:0] tb_mem [4];
    logic [7:0] rd_data;
    always @(posedge clk) if (mem_wr_en) tb_mem[mem_wr_addr] <= wdata;
    assign rd_data = tb_mem[mem_rd_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         wr, rd;
        logic [7:0] din;
        int         cnt;
        bit         full, empty, werr, rerr;
        int         wa, ra;
        bit         chk_data;
        logic [7:0] dout;
    } vec_t;

    function automatic vec_t mk(bit wr, bit rd, logic [7:0] din, int cnt, bit f, bit e,
                                bit we, bit re, int wa, int ra, bit cd, logic [7:0] dout);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt; v.full = f; v.empty = e;
        v.werr = we; v.rerr = re; v.wa = wa; v.ra = ra; v.chk_data = cd; v.dout = dout;
        return v;
    endfunction

    // Inputs applied at posedge+1; outputs of that edge checked at next posedge+1.
    task automatic cycle(input bit w, input bit r, input logic [7:0] d);
        wr_req = w; rd_req = r; wdata = d;
        @(posedge clk); #1;
    endtask

    task automatic cycle3(input bit w, input bit r);
        wr3 = w; rd3 = r;
        @(posedge clk); #1;
    endtask

    vec_t       vecs[13];
    bit         prev_full;
    logic [7:0] q[$];
    int         wa, ra, wa3, ra3;

    initial begin
        reset = 1'b1; wr_req = 0; rd_req = 0; wdata = '0; wr3 = 0; rd3 = 0;
        vecs[0]  = mk(1, 0, 8'h11, 1, 0, 0, 0, 0, 1, 0, 1, 8'h11);
        vecs[1]  = mk(1, 0, 8'h22, 2, 0, 0, 0, 0, 2, 0, 1, 8'h11);
        vecs[2]  = mk(1, 0, 8'h33, 3, 0, 0, 0, 0, 3, 0, 1, 8'h11);
        vecs[3]  = mk(1, 0, 8'h44, 4, 1, 0, 0, 0, 0, 0, 1, 8'h11);
        vecs[4]  = mk(1, 0, 8'h55, 4, 1, 0, 1, 0, 0, 0, 1, 8'h11);
        vecs[5]  = mk(0, 0, 8'h00, 4, 1, 0, 0, 0, 0, 0, 1, 8'h11);
        vecs[6]  = mk(1, 1, 8'h66, 3, 0, 0, 1, 0, 0, 1, 1, 8'h22);
        vecs[7]  = mk(0, 1, 8'h00, 2, 0, 0, 0, 0, 0, 2, 1, 8'h33);
        vecs[8]  = mk(0, 1, 8'h00, 1, 0, 0, 0, 0, 0, 3, 1, 8'h44);
        vecs[9]  = mk(0, 1, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
        vecs[10] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00);
        vecs[11] = mk(1, 1, 8'h77, 1, 0, 0, 0, 1, 1, 0, 1, 8'h77);
        vecs[12] = mk(0, 1, 8'h00, 0, 0, 1, 0, 0, 1, 1, 0, 8'h00);

        #12;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_addr", mem_wr_addr, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        chk("rst_errs", {wr_err, rd_err}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        prev_full = 1'b0;
        foreach (vecs[i]) begin
            wr_req = vecs[i].wr; rd_req = vecs[i].rd; wdata = vecs[i].din;
            #1;
            chk($sformatf("v%0d_wr_en", i), mem_wr_en, vecs[i].wr & ~prev_full);
            @(posedge clk); #1;
            chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("v%0d_full", i), full, vecs[i].full);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].empty);
            chk($sformatf("v%0d_wr_err", i), wr_err, vecs[i].werr);
            chk($sformatf("v%0d_rd_err", i), rd_err, vecs[i].rerr);
            chk($sformatf("v%0d_wr_addr", i), mem_wr_addr, vecs[i].wa);
            chk($sformatf("v%0d_rd_addr", i), mem_rd_addr, vecs[i].ra);
            if (vecs[i].chk_data) chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].dout);
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
            chk($sformatf("v%0d_almost_full", i), almost_full, vecs[i].cnt >= 3);
            chk($sformatf("v%0d_almost_empty", i), almost_empty, vecs[i].cnt <= 1);
`endif
            prev_full = vecs[i].full;
        end
        wr_req = 0; rd_req = 0;

        // Steady push+pop at occupancy 2 across a pointer wrap.
        wa = 1; ra = 1;
        cycle(1, 0, 8'hAA);
        cycle(1, 0, 8'hBB);
        q = '{8'hAA, 8'hBB};
        wa = 3;
        chk("sim_pre_count", count, 2);
        chk("sim_pre_data", rd_data, q[0]);
        for (int k = 0; k < 10; k++) begin
            cycle(1, 1, 8'h30 + 8'(k));
            q.push_back(8'h30 + 8'(k));
            void'(q.pop_front());
            wa = (wa + 1) % 4;
            ra = (ra + 1) % 4;
            chk($sformatf("sim%0d_count", k), count, 2);
            chk($sformatf("sim%0d_wr_addr", k), mem_wr_addr, wa);
            chk($sformatf("sim%0d_rd_addr", k), mem_rd_addr, ra);
            chk($sformatf("sim%0d_rd_data", k), rd_data, q[0]);
        end

        // Asynchronous reset in the middle of a cycle with the FIFO full.
        cycle(1, 0, 8'hC1);
        cycle(1, 0, 8'hC2);
        chk("pre_rst_full", full, 1);
        wr_req = 1; rd_req = 1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_addrs", {mem_wr_addr, mem_rd_addr}, 0);
        wr_req = 0; rd_req = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_empty", empty, 1);
        chk("post_rst_count", count, 0);

        // Depth 3: fill, overflow, drain, then alternating rounds.
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d3_fill%0d_wa", k), wa3_o, k);
            cycle3(1, 0);
            chk($sformatf("d3_fill%0d_count", k), count3, k + 1);
            chk($sformatf("d3_fill%0d_full", k), full3, k == 2);
        end
        chk("d3_wrap_wa", wa3_o, 0);
        cycle3(1, 0);
        chk("d3_ovf_werr", werr3, 1);
        chk("d3_ovf_count", count3, 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d3_drain%0d_ra", k), ra3_o, k);
            cycle3(0, 1);
        end
        chk("d3_drain_empty", empty3, 1);
        chk("d3_drain_werr", werr3, 0);
        wa3 = 0; ra3 = 0;
        for (int r = 0; r < 7; r++) begin
            chk($sformatf("d3_r%0d_wa", r), wa3_o, wa3);
            cycle3(1, 0);
            wa3 = (wa3 + 1) % 3;
            chk($sformatf("d3_r%0d_ra", r), ra3_o, ra3);
            chk($sformatf("d3_r%0d_count", r), count3, 1);
            cycle3(0, 1);
            ra3 = (ra3 + 1) % 3;
            chk($sformatf("d3_r%0d_empty", r), empty3, 1);
        end
        chk("d3_end_wa", wa3_o, 1);
        chk("d3_end_ra", ra3_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
